// File: rtl/eth_udp_extract.sv
// eth_udp_extract: byte-serial Ethernet/IPv4/UDP parser that packs the UDP payload into 32-bit words
// Ports: clk, rst (async, active-low); newpacket/in_last_addr start a parse of the input RAM,
//   rd_addr/rd_data read it (1-cycle latency); wr_addr/wr_data/wr_ena write the payload RAM;
//   busy/done/drop/drop_reason report status; payload_len/last_addr/valid_ip/valid_udp describe the frame.
// Optional: define UDP_PORT_FILTER_EN to accept only destination port UDP_PORT (else drop, reason 5).
module eth_udp_extract #(
  parameter int ADDR_W = 9,
  parameter int NIBBLE_SWAP = 1,
  parameter int PRE_MIN = 4,
  parameter int SFD_SEARCH = 16,
  parameter int MAX_PAYLOAD = 1252,
  parameter logic [15:0] UDP_PORT = 16'd5000
) (
  input  logic clk,
  input  logic rst,
  input  logic newpacket,
  input  logic [ADDR_W-1:0] in_last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0] wr_data,
  output logic wr_ena,
  output logic busy,
  output logic done,
  output logic drop,
  output logic [2:0] drop_reason,
  output logic [15:0] payload_len,
  output logic [ADDR_W-1:0] last_addr,
  output logic valid_ip,
  output logic valid_udp
);
  localparam logic [3:0] IDLE = 4'd0, FIND_SFD = 4'd1, ETH_HDR = 4'd2, IP_HDR = 4'd3, IP_OPTS = 4'd4,
                         UDP_HDR = 4'd5, PAYLOAD = 4'd6, DONE = 4'd7, DROP = 4'd8;
  logic [3:0] st;
  // one spare top bit flags index overflow instead of wrapping
  logic [ADDR_W+2:0] bi;
  logic [ADDR_W-1:0] last_q, wa;
  logic pv, pbad, beyond, port_bad;
  logic [1:0] psel;
  logic [15:0] cnt, len_w, opt_n;
  logic [7:0] run, hold_b, raw, b;
  logic [3:0] ihl;
  logic [31:0] pack, pack_nx;
  assign rd_addr = bi[ADDR_W+1:2];
  assign beyond = bi[ADDR_W+2] | (bi[ADDR_W+1:2] > last_q);
  assign len_w = {hold_b, b};
  assign opt_n = {10'd0, ihl - 4'd5, 2'b00};
`ifdef UDP_PORT_FILTER_EN
  assign port_bad = (cnt == 16'd3) && ({hold_b, b} != UDP_PORT);
`else
  assign port_bad = 1'b0 & (UDP_PORT != 16'd0);
`endif
  always_comb begin
    raw = rd_data[{psel, 3'b000} +: 8];
    b = (NIBBLE_SWAP != 0) ? {raw[3:0], raw[7:4]} : raw;
    pack_nx = (cnt[1:0] == 2'd0) ? 32'd0 : pack;
    pack_nx[{cnt[1:0], 3'b000} +: 8] = b;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      bi <= '0;
      last_q <= '0;
      wa <= '0;
      pv <= 1'b0;
      pbad <= 1'b0;
      psel <= 2'd0;
      cnt <= 16'd0;
      run <= 8'd0;
      hold_b <= 8'd0;
      ihl <= 4'd0;
      pack <= 32'd0;
      wr_addr <= '0;
      wr_data <= 32'd0;
      wr_ena <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
      drop_reason <= 3'd0;
      payload_len <= 16'd0;
      last_addr <= '0;
      valid_ip <= 1'b0;
      valid_udp <= 1'b0;
    end else begin
      wr_ena <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
      // fetch stage: issue one byte address per cycle while parsing; the byte is consumed next cycle
      pv <= 1'b0;
      if (st != IDLE && st != DONE && st != DROP) begin
        bi <= bi + {{(ADDR_W+2){1'b0}}, ~bi[ADDR_W+2]};
        pv <= 1'b1;
        pbad <= beyond;
        psel <= bi[1:0];
      end
      case (st)
        IDLE: if (newpacket) begin
          bi <= '0;
          last_q <= in_last_addr;
          valid_ip <= 1'b0;
          valid_udp <= 1'b0;
          drop_reason <= 3'd0;
          busy <= 1'b1;
          cnt <= 16'd0;
          run <= 8'd0;
          wa <= '0;
          st <= FIND_SFD;
        end
        DONE: begin
          last_addr <= wa;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        DROP: begin
          drop <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: if (pv) begin
          cnt <= cnt + 16'd1;
          if (pbad) begin
            drop_reason <= 3'd7;
            st <= DROP;
          end else begin
            case (st)
              FIND_SFD: begin
                run <= (b == 8'h55) ? run + {7'd0, run != 8'hFF} : 8'd0;
                if (b == 8'hD5 && run >= 8'(PRE_MIN)) begin
                  st <= ETH_HDR;
                  cnt <= 16'd0;
                end else if (cnt == 16'(SFD_SEARCH - 1)) begin
                  drop_reason <= 3'd1;
                  st <= DROP;
                end
              end
              ETH_HDR: begin
                if ((cnt == 16'd12 && b != 8'h08) || (cnt == 16'd13 && b != 8'h00)) begin
                  drop_reason <= 3'd2;
                  st <= DROP;
                end else if (cnt == 16'd13) begin
                  valid_ip <= 1'b1;
                  st <= IP_HDR;
                  cnt <= 16'd0;
                end
              end
              IP_HDR: begin
                if (cnt == 16'd0) ihl <= b[3:0];
                if (cnt == 16'd0 && (b[7:4] != 4'd4 || b[3:0] < 4'd5)) begin
                  drop_reason <= 3'd3;
                  st <= DROP;
                end else if (cnt == 16'd9 && b != 8'h11) begin
                  drop_reason <= 3'd4;
                  st <= DROP;
                end else if (cnt == 16'd19) begin
                  st <= (ihl > 4'd5) ? IP_OPTS : UDP_HDR;
                  cnt <= 16'd0;
                end
              end
              IP_OPTS: if (cnt == opt_n - 16'd1) begin
                st <= UDP_HDR;
                cnt <= 16'd0;
              end
              UDP_HDR: begin
                // hold_b keeps the high byte of the port (byte 2) and length (byte 4)
                if (cnt == 16'd2 || cnt == 16'd4) hold_b <= b;
                if (port_bad) begin
                  drop_reason <= 3'd5;
                  st <= DROP;
                end else if (cnt == 16'd5 && (len_w < 16'd8 || len_w - 16'd8 > 16'(MAX_PAYLOAD))) begin
                  drop_reason <= 3'd6;
                  st <= DROP;
                end else if (cnt == 16'd5) begin
                  payload_len <= len_w - 16'd8;
                end else if (cnt == 16'd7) begin
                  valid_udp <= 1'b1;
                  st <= (payload_len == 16'd0) ? DONE : PAYLOAD;
                  cnt <= 16'd0;
                end
              end
              PAYLOAD: begin
                pack <= pack_nx;
                if (cnt[1:0] == 2'd3 || cnt == payload_len - 16'd1) begin
                  wr_ena <= 1'b1;
                  wr_data <= pack_nx;
                  wr_addr <= cnt[ADDR_W+1:2];
                  wa <= cnt[ADDR_W+1:2];
                end
                if (cnt == payload_len - 16'd1) st <= DONE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end
endmodule
